// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the hazard-aware 5-stage RISC-V pipeline.
package rv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a NOP bubble, or hold.
module ifid_pipe_reg #(
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Bubbles keep the previous PC so downstream debug/trace sees a stable value.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
    end else if (bubble) begin
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;

endmodule

// File: rtl/if_stage_hazard.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem fetch FSM,
// and feeds the IF/ID register under hazard-unit stall and branch flush control.
module if_stage_hazard #(
  parameter logic [31:0] RESET_PC  = rv_pipe_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IFIDWrite,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IFID,
  output logic [31:0] Instruc_IFID
);

  import rv_pipe_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;

  // Request is masked during reset so the shared-reset memory never sees a fetch.
  assign imem_req  = (state_q == REQ) && !rst;
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ibuf_d     = ibuf_q;
    ifid_load  = 1'b0;
    ifid_instr = imem_rdata;
    if (flush) begin
      pc_d = {branch_target[31:2], 2'b00};
      unique case (state_q)
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        REQ:     state_d = imem_gnt ? DROP : REQ;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: if (imem_gnt) state_d = WAIT;
        WAIT: if (imem_rvalid) begin
          if (IFIDWrite) begin
            ifid_load = 1'b1;
            pc_d      = pc_q + 32'd4;
            state_d   = REQ;
          end else begin
            ibuf_d  = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD: if (IFIDWrite) begin
          ifid_load  = 1'b1;
          ifid_instr = ibuf_q;
          pc_d       = pc_q + 32'd4;
          state_d    = REQ;
        end
        DROP: if (imem_rvalid) state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  // A flush squashes IF/ID even while the hazard unit is stalling it.
  assign ifid_bubble = flush | IFIDWrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      ibuf_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
    end
  end

  ifid_pipe_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load & ~flush),
    .bubble   (ifid_bubble),
    .pc_in    (pc_q),
    .instr_in (ifid_instr),
    .pc_out   (PC_IFID),
    .instr_out(Instruc_IFID)
  );

endmodule

// File: tb/tb_if_stage_hazard.sv
// Bench for if_stage_hazard: directed scenarios plus randomized traffic against a
// transaction-level fetch model and a behavioural instruction memory.
module tb_if_stage_hazard;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        IFIDWrite, flush, imem_gnt, imem_rvalid, imem_req;
  logic [31:0] branch_target, imem_rdata, imem_addr, PC_IFID, Instruc_IFID;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  if_stage_hazard #(
    .RESET_PC (RPC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .IFIDWrite    (IFIDWrite),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .PC_IFID      (PC_IFID),
    .Instruc_IFID (Instruc_IFID)
  );

  // Behavioural memory: one outstanding transaction, latency lat_min..lat_max.
  bit          mem_busy;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;
  int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1;

  // Reference model: what the fetch stage owes, in transaction terms.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr, m_hbuf;
  bit          m_fetching, m_stale, m_held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit m_req();
    return !(m_fetching || m_stale || m_held);
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_ifid_pc = '0; m_ifid_instr = NOP; m_hbuf = '0;
    m_fetching = 0; m_stale = 0; m_held = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0;
  endtask

  // Drives one clock of stimulus (memory answers the DUT's request) and advances the model.
  task automatic step(input bit wr, input bit fl, input logic [31:0] tgt);
    bit gnt, rv, req_now, delivered;
    logic [31:0] rdata;
    rv = 0; rdata = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin rv = 1; rdata = mem_word(mem_addr); mem_busy = 0; end
    end
    gnt = 0;
    if (imem_req === 1'b1 && !mem_busy && $urandom_range(99) < gnt_pct) begin
      gnt = 1; mem_busy = 1; mem_addr = imem_addr;
      mem_cnt = $urandom_range(lat_max, lat_min);
    end
    IFIDWrite = wr; flush = fl; branch_target = tgt;
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
    req_now = m_req(); delivered = 0;
    if (fl) begin
      m_stale = (m_fetching && !rv) || (req_now && gnt);
      m_fetching = 0; m_held = 0;
      m_pc = {tgt[31:2], 2'b00};
      m_ifid_instr = NOP;
    end else begin
      if (req_now && gnt) m_fetching = 1;
      else if (m_fetching && rv) begin
        m_fetching = 0;
        if (wr) begin
          m_ifid_pc = m_pc; m_ifid_instr = mem_word(m_pc); m_pc += 32'd4; delivered = 1;
        end else begin
          m_held = 1; m_hbuf = mem_word(m_pc);
        end
      end else if (m_held && wr) begin
        m_held = 0; m_ifid_pc = m_pc; m_ifid_instr = m_hbuf; m_pc += 32'd4; delivered = 1;
      end else if (m_stale && rv) m_stale = 0;
      if (wr && !delivered) m_ifid_instr = NOP;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; IFIDWrite = 1; flush = 0; branch_target = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || PC_IFID !== 32'h0 || Instruc_IFID !== NOP) begin
      miscompares++;
      $display("FAIL reset_state: req/pc/instr got %b/%h/%h want 0/00000000/%h",
               imem_req, PC_IFID, Instruc_IFID, NOP);
    end
    rst = 0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      miscompares++;
      $display("FAIL reset_release: req/addr got %b/%h want 1/%h", imem_req, imem_addr, RPC);
    end
  endtask

  task automatic test_basic_fetch();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    step(1, 0, '0);
    step(1, 0, '0);
    vectors++;
    if (PC_IFID !== 32'h0 || Instruc_IFID !== 32'h00A0_0093) begin
      miscompares++;
      $display("FAIL basic_first: ifid got %h/%h want 00000000/00a00093", PC_IFID, Instruc_IFID);
    end
    step(1, 0, '0);
    step(1, 0, '0);
    vectors++;
    if (PC_IFID !== 32'h4 || Instruc_IFID !== 32'h0010_0113) begin
      miscompares++;
      $display("FAIL basic_second: ifid got %h/%h want 00000004/00100113", PC_IFID, Instruc_IFID);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] held_pc, held_instr;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL stall_req8: req/addr got %b/%h want 1/00000008", imem_req, imem_addr);
    end
    step(1, 0, '0);
    held_pc = m_ifid_pc; held_instr = m_ifid_instr;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0);
      vectors++;
      if (imem_req !== 1'b0 || PC_IFID !== held_pc || Instruc_IFID !== held_instr) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: req/pc/instr got %b/%h/%h want 0/%h/%h",
                 i, imem_req, PC_IFID, Instruc_IFID, held_pc, held_instr);
      end
    end
    step(1, 0, '0);
    vectors++;
    if (PC_IFID !== 32'h8 || Instruc_IFID !== mem_word(32'h8) || imem_req !== 1'b1
        || imem_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL stall_release: pc/instr/req/addr got %h/%h/%b/%h want 00000008/%h/1/0000000c",
               PC_IFID, Instruc_IFID, imem_req, imem_addr, mem_word(32'h8));
    end
  endtask

  task automatic test_flush_wait();
    logic [31:0] pc_before;
    bit found;
    lat_min = 3; lat_max = 3;
    step(1, 0, '0);
    pc_before = PC_IFID;
    step(1, 1, 32'h0000_0102);
    vectors++;
    if (imem_req !== 1'b0 || Instruc_IFID !== NOP || PC_IFID !== pc_before) begin
      miscompares++;
      $display("FAIL flush_wait_drop: req/pc/instr got %b/%h/%h want 0/%h/%h",
               imem_req, PC_IFID, Instruc_IFID, pc_before, NOP);
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req === 1'b1) found = 1;
      else step(1, 0, '0);
    end
    vectors++;
    if (!found || imem_addr !== 32'h0000_0100 || Instruc_IFID !== NOP) begin
      miscompares++;
      $display("FAIL flush_wait_redirect: found/addr/instr got %0d/%h/%h want 1/00000100/%h",
               found, imem_addr, Instruc_IFID, NOP);
    end
  endtask

  task automatic test_flush_rvalid();
    lat_min = 1; lat_max = 1;
    step(1, 0, '0);
    step(0, 1, 32'h0000_0200);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || Instruc_IFID !== NOP) begin
      miscompares++;
      $display("FAIL flush_rvalid: req/addr/instr got %b/%h/%h want 1/00000200/%h",
               imem_req, imem_addr, Instruc_IFID, NOP);
    end
  endtask

  task automatic test_latency_wrap();
    logic [31:0] pc_hold;
    gnt_pct = 0;
    step(1, 1, 32'hFFFF_FFFE);
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_req: req/addr got %b/%h want 1/fffffffc", imem_req, imem_addr);
    end
    step(1, 0, '0);
    pc_hold = PC_IFID;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0);
      vectors++;
      if (PC_IFID !== pc_hold || Instruc_IFID !== NOP || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_bubble[%0d]: pc/instr/req got %h/%h/%b want %h/%h/0",
                 i, PC_IFID, Instruc_IFID, imem_req, pc_hold, NOP);
      end
    end
    step(1, 0, '0);
    vectors++;
    if (PC_IFID !== 32'hFFFF_FFFC || Instruc_IFID !== mem_word(32'hFFFF_FFFC)
        || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next: pc/instr/req/addr got %h/%h/%b/%h want fffffffc/%h/1/00000000",
               PC_IFID, Instruc_IFID, imem_req, imem_addr, mem_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(99) < 80, $urandom_range(99) < 8, $urandom);
      vectors++;
      if (imem_req !== m_req() || (m_req() && imem_addr !== m_pc)
          || PC_IFID !== m_ifid_pc || Instruc_IFID !== m_ifid_instr) begin
        miscompares++;
        $display("FAIL random[%0d]: req/addr/pc/instr got %b/%h/%h/%h want %b/%h/%h/%h",
                 n, imem_req, imem_addr, PC_IFID, Instruc_IFID,
                 m_req(), m_pc, m_ifid_pc, m_ifid_instr);
      end
    end
  endtask

  task automatic test_reset_midfetch();
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && !m_fetching; i++) step(1, 0, '0);
    vectors++;
    if (!m_fetching || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_setup: in_wait/req got %0d/%b want 1/0", m_fetching, imem_req);
    end
    #2 rst = 1;
    imem_gnt = 0; imem_rvalid = 0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || PC_IFID !== 32'h0 || Instruc_IFID !== NOP) begin
      miscompares++;
      $display("FAIL midreset_async: req/pc/instr got %b/%h/%h want 0/00000000/%h",
               imem_req, PC_IFID, Instruc_IFID, NOP);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      miscompares++;
      $display("FAIL midreset_first_req: req/addr got %b/%h want 1/%h", imem_req, imem_addr, RPC);
    end
    for (int n = 0; n < 12; n++) begin
      step(1, 0, '0);
      vectors++;
      if (imem_req !== m_req() || PC_IFID !== m_ifid_pc || Instruc_IFID !== m_ifid_instr) begin
        miscompares++;
        $display("FAIL midreset_run[%0d]: req/pc/instr got %b/%h/%h want %b/%h/%h",
                 n, imem_req, PC_IFID, Instruc_IFID, m_req(), m_ifid_pc, m_ifid_instr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_flush_wait();
    test_flush_rvalid();
    test_latency_wrap();
    test_random();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage_hazard.md
# if_stage_hazard

Instruction-fetch stage of the hazard-aware 5-stage RISC-V pipeline, sitting directly upstream of the ID stage. It owns the PC and fetches instructions over a single-outstanding request/response instruction-memory port. It drives the IF/ID pipeline register (`PC_IFID`, `Instruc_IFID`). It honours the hazard unit's IF/ID stall and the branch-resolution flush/redirect, inserting NOP bubbles where no valid instruction exists.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `IFIDWrite` in 1: hazard-unit enable. 0 = stall: PC and IF/ID hold.
- `flush` in 1: taken branch resolved downstream; redirect to `branch_target`.
- `branch_target` in 32: redirect address; bits [1:0] forced to 0.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address (= PC), stable while `imem_req`=1.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word, qualified by `imem_rvalid`.
- `PC_IFID` out 32: registered PC of the instruction in IF/ID.
- `Instruc_IFID` out 32: registered instruction, or `NOP_INSTR`.

## Operation
- Registers: `pc` (32), `ibuf` (32), `state` ∈ {REQ, WAIT, HOLD, DROP}, `PC_IFID`, `Instruc_IFID`.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt` go to WAIT, else stay.
- WAIT: `imem_req`=0. On `imem_rvalid`:
  - `IFIDWrite`=1: IF/ID ← {`pc`, `imem_rdata`}, `pc` ← `pc`+4, go to REQ.
  - `IFIDWrite`=0: `ibuf` ← `imem_rdata`, go to HOLD.
- HOLD: `imem_req`=0. When `IFIDWrite`=1: IF/ID ← {`pc`, `ibuf`}, `pc` ← `pc`+4, go to REQ.
- DROP: `imem_req`=0. Discard the next `imem_rvalid` (no IF/ID or `ibuf` update), then go to REQ.
- Bubble: in any cycle with `IFIDWrite`=1 and no instruction delivered, IF/ID ← {`PC_IFID` unchanged, `NOP_INSTR`}. With `IFIDWrite`=0, IF/ID holds.
- Flush has the highest priority and overrides the stall:
  - `pc` ← {`branch_target`[31:2], 2'b00}.
  - IF/ID ← {`PC_IFID`, `NOP_INSTR`}.
  - Next state:
    - WAIT without `imem_rvalid` → DROP.
    - WAIT with `imem_rvalid` → REQ (the data is discarded).
    - REQ with `imem_gnt` → DROP.
    - Otherwise → REQ.
- `imem_rvalid` in REQ or HOLD is a protocol violation; it is ignored.
- PC arithmetic is modulo 2^32: `pc`+4 at 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset (async assert, sync release): `pc`=`RESET_PC`, `state`=REQ, `ibuf`=0, `PC_IFID`=0, `Instruc_IFID`=`NOP_INSTR`. `imem_req`=0 while `rst`=1 and 1 in the first cycle after release.
- `imem_req` and `imem_addr` are decoded from registered state and `pc` only (no input-to-output combinational path).
- Latency: grant in cycle N, `imem_rvalid` in cycle N+k (k≥1). IF/ID is visible in cycle N+k+1, and the next request is issued in cycle N+k+1.
- Best-case throughput is 1 instruction per 2 cycles. Pipelined fetch is out of scope.
- Reset mid-fetch: the memory shares `rst`, so any in-flight transaction is abandoned; there is no DROP after reset.
- A stall during REQ does not block the request; the fetch proceeds and buffers in HOLD.

## Structure
- Shared package `rv_pipe_pkg`: `NOP_INSTR` constant, `fetch_state_t` enum {REQ, WAIT, HOLD, DROP}, default `RESET_PC`.
- One natural sub-module: `ifid_pipe_reg`, the IF/ID register with load/bubble/hold controls and reset to {0, `NOP_INSTR`}. FSM, PC and `ibuf` stay in the top module.

## Test plan
- Reset then free-run, memory returning `0x00A00093`, `0x00100113` with k=1: requests at 0x0, 0x4. IF/ID shows (0x0, 0x00A00093) in cycle 3, then (0x4, 0x00100113) two cycles later.
- `IFIDWrite`=0 for 3 cycles across an `imem_rvalid` at PC 0x8: HOLD entered, IF/ID unchanged. On release, IF/ID = (0x8, `ibuf` data) and next request addr 0xC.
- `flush` with `branch_target`=0x0000_0102 while in WAIT: response discarded via DROP, IF/ID = NOP, next `imem_addr`=0x0000_0100.
- `flush` in the same cycle as `imem_rvalid` and `IFIDWrite`=0: flush wins. IF/ID = NOP, no HOLD, next request at the target.
- Memory latency k=4 with `IFIDWrite`=1: three NOP bubbles, `PC_IFID` held constant. `pc` at 0xFFFF_FFFC wraps to next fetch 0x0.
- Assert `rst` during WAIT: outputs return to reset values immediately; first post-reset request at `RESET_PC`.
